debounce_bank: RTL and testbench
================================

DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 Parameter N, default 4: number of independent input channels, 1..32.
REQ-002 Parameter STABLE_CYCLES, default 2097152: consecutive sampled cycles an input must differ from the debounced level before the level changes; legal range is 2 or more.
REQ-003 Parameter INVERT, default {N{1'b0}}: per-channel mask; a set bit inverts that raw input before synchronisation.
REQ-004 Parameter REPEAT_DELAY, default 25000000: cycles from a rising edge to the first repeat pulse; used only with the repeat feature.
REQ-005 Parameter REPEAT_PERIOD, default 5000000: cycles between later repeat pulses; used only with the repeat feature.
REQ-006 Reset is rstn, synchronous, active-low; the clock is clk.
REQ-007 clk  input  1  system clock; all state is updated on the rising edge.
REQ-008 rstn  input  1  synchronous active-low reset.
REQ-009 din  input  N  raw asynchronous inputs (buttons or switches).
REQ-010 level_o  output  N  debounced level per channel, registered.
REQ-011 rise_o  output  N  one-cycle pulse when level_o goes 0 to 1.
REQ-012 fall_o  output  N  one-cycle pulse when level_o goes 1 to 0.
REQ-013 repeat_o  output  N  one-cycle auto-repeat pulse per channel.
REQ-014 any_rise_o  output  1  OR of all rise_o bits.

Function
REQ-015 Each channel passes (din XOR INVERT) through a 2-flop synchroniser; the second flop (sync) is the only signal compared against level.
REQ-016 Each channel has a counter of width $clog2(STABLE_CYCLES); when sync equals level, the counter is cleared on that edge.
REQ-017 When sync differs from level and count is below STABLE_CYCLES-1, the counter increments.
REQ-018 When sync differs from level and count equals STABLE_CYCLES-1, level toggles, the counter clears, and rise_o or fall_o asserts for exactly that one following cycle.
REQ-019 Any return of sync to level before the threshold clears the counter; glitches shorter than STABLE_CYCLES produce no output activity.
REQ-020 Latency: if the first edge that samples a new din value is edge 1, level_o changes after edge STABLE_CYCLES+2; the change requires din to have been stable throughout.
REQ-021 The counter never wraps; it saturates logically because it clears at the threshold.
REQ-022 Channels are fully independent; simultaneous transitions on several channels produce simultaneous pulses.
REQ-023 rise_o and fall_o for the same channel are never high in the same cycle.
REQ-024 any_rise_o is combinational from the registered rise_o and is high in exactly the cycles in which any bit of rise_o is high.

Reset
REQ-025 While rstn=0 at an edge, the synchroniser flops, level_o, the counters, rise_o, fall_o, repeat_o and the repeat counters all clear to 0.
REQ-026 A reset asserted mid-count discards the partial count; after release, counting restarts from 0.
REQ-027 An input held active through reset produces a rise_o pulse STABLE_CYCLES+2 edges after reset release.

Configuration
REQ-028 With DEBOUNCE_BANK_REPEAT_EN defined, each channel counts while level_o=1 and pulses repeat_o REPEAT_DELAY cycles after its rise_o pulse, then every REPEAT_PERIOD cycles.
REQ-029 With DEBOUNCE_BANK_REPEAT_EN defined, a fall_o or reset clears the repeat state, so no repeat pulse follows fall_o.
REQ-030 Without DEBOUNCE_BANK_REPEAT_EN, repeat_o is tied to 0, the port remains, and no repeat logic is synthesised.

Structure
REQ-031 Package debounce_pkg holds the default constants (STABLE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) and a counter-width function.
REQ-032 Per-channel logic (synchroniser, counter, level, pulses, repeat) resides in sub-module debounce_cell, instantiated N times by a generate loop.

Verification (N=2, STABLE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3)
REQ-033 din[0] rises and is held -> level_o[0]=1 after edge 6; rise_o[0]=1 for exactly one cycle; any_rise_o matches rise_o; channel 1 stays quiet.
REQ-034 din[0] high for 3 cycles then low -> level_o, rise_o and fall_o remain 0 throughout.
REQ-035 Bouncing din[1] (1,0,1,1,0,1,1,1,1 …) -> single rise_o[1], 4 sampled cycles after the last bounce.
REQ-036 Both channels rise on the same edge, and INVERT=2'b10 with din[1] falling -> both rise_o bits pulse in the same cycle.
REQ-037 rstn asserted while count=2 -> all outputs 0; an input still high after release rises 6 edges after release.
REQ-038 With the repeat macro defined, din[0] held high for 20 cycles after rise_o -> repeat_o[0] at +8, +11, +14, +17; after fall_o, no further repeat_o.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared defaults and sizing helper for the debounce bank.
package debounce_pkg;

  localparam int unsigned DEF_STABLE_CYCLES = 2097152;
  localparam int unsigned DEF_REPEAT_DELAY  = 25000000;
  localparam int unsigned DEF_REPEAT_PERIOD = 5000000;

  // Width of a counter that must reach limit-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit <= 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// One debounce channel: 2-flop synchroniser, stability counter, level/edge pulses
// and, with DEBOUNCE_BANK_REPEAT_EN defined, an auto-repeat generator.
module debounce_cell
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter logic        INV           = 1'b0
`ifdef DEBOUNCE_BANK_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
`endif
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic repeat_o
);

  localparam int unsigned   CW      = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          hit;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    hit     = (sync2_q != level_q) && (cnt_q == CNT_MAX);
    cnt_d   = ((sync2_q == level_q) || hit) ? '0 : cnt_q + 1'b1;
    level_d = level_q ^ hit;
    rise_d  = hit & ~level_q;
    fall_d  = hit & level_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= din ^ INV;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

`ifdef DEBOUNCE_BANK_REPEAT_EN
  localparam int unsigned   RMAX    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned   RW      = cnt_width(RMAX);
  localparam logic [RW-1:0] DLY_MAX = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_MAX = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          first_q, first_d;
  logic          repeat_q, repeat_d;

  // Any level toggle restarts the schedule; a falling toggle also suppresses
  // a pulse that would otherwise land on the same edge.
  always_comb begin
    rep_cnt_d = rep_cnt_q;
    first_d   = first_q;
    repeat_d  = 1'b0;
    if (hit) begin
      rep_cnt_d = '0;
      first_d   = 1'b1;
    end else if (level_q) begin
      if (rep_cnt_q == (first_q ? DLY_MAX : PER_MAX)) begin
        repeat_d  = 1'b1;
        rep_cnt_d = '0;
        first_d   = 1'b0;
      end else begin
        rep_cnt_d = rep_cnt_q + 1'b1;
      end
    end else begin
      rep_cnt_d = '0;
      first_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rep_cnt_q <= '0;
      first_q   <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      first_q   <= first_d;
      repeat_q  <= repeat_d;
    end
  end

  assign repeat_o = repeat_q;
`else
  assign repeat_o = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// Bank of N independent debounced inputs with edge pulses and an any-rise flag.
// Optional auto-repeat is enabled by defining DEBOUNCE_BANK_REPEAT_EN.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int unsigned N             = 4,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter logic [N-1:0] INVERT       = {N{1'b0}},
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] din,
  output logic [N-1:0] level_o,
  output logic [N-1:0] rise_o,
  output logic [N-1:0] fall_o,
  output logic [N-1:0] repeat_o,
  output logic         any_rise_o
);

  if (N < 1 || N > 32 || STABLE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1)
  begin : g_param_check
    $error("debounce_bank: illegal parameter value");
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    debounce_cell #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .INV           (INVERT[i])
`ifdef DEBOUNCE_BANK_REPEAT_EN
      ,
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
    ) u_cell (
      .clk      (clk),
      .rstn     (rstn),
      .din      (din[i]),
      .level_o  (level_o[i]),
      .rise_o   (rise_o[i]),
      .fall_o   (fall_o[i]),
      .repeat_o (repeat_o[i])
    );
  end

  assign any_rise_o = |rise_o;

endmodule

// File: tb/tb_debounce_bank.sv
// Scoreboard bench for debounce_bank (N=2, STABLE_CYCLES=4, REPEAT 8/3).
module tb_debounce_bank;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [1:0] din = 2'b00;
  logic [1:0] din_inv = 2'b10;
  logic [1:0] lv0, rs0, fl0, rp0, lv1, rs1, fl1, rp1;
  logic       ar0, ar1;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic [1:0] lv, rs, fl, rp;
  } evt_t;

  evt_t q0[$];
  evt_t q1[$];

  debounce_bank #(.N(2), .STABLE_CYCLES(4), .INVERT(2'b00), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)) dut (
    .clk(clk), .rstn(rstn), .din(din), .level_o(lv0), .rise_o(rs0), .fall_o(fl0),
    .repeat_o(rp0), .any_rise_o(ar0)
  );

  debounce_bank #(.N(2), .STABLE_CYCLES(4), .INVERT(2'b10), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)) dut_inv (
    .clk(clk), .rstn(rstn), .din(din_inv), .level_o(lv1), .rise_o(rs1), .fall_o(fl1),
    .repeat_o(rp1), .any_rise_o(ar1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cmp(input string tag, input evt_t e, input logic [1:0] lv, input logic [1:0] rs,
                     input logic [1:0] fl, input logic [1:0] rp, input logic ar);
    chk({tag, " event cycle"}, cyc, e.cyc);
    chk({tag, " level_o"}, int'(lv), int'(e.lv));
    chk({tag, " rise_o"}, int'(rs), int'(e.rs));
    chk({tag, " fall_o"}, int'(fl), int'(e.fl));
    chk({tag, " repeat_o"}, int'(rp), int'(e.rp));
    chk({tag, " any_rise_o"}, int'(ar), int'(e.rs != 2'b00));
  endtask

  function automatic void push(input int id, input int c, input logic [1:0] lv, input logic [1:0] rs,
                               input logic [1:0] fl, input logic [1:0] rp);
    evt_t e;
    e.cyc = c; e.lv = lv; e.rs = rs; e.fl = fl; e.rp = rp;
    if (id == 0) q0.push_back(e);
    else q1.push_back(e);
  endfunction

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag, input logic [1:0] lv, input logic [1:0] rs,
                          input logic [1:0] fl, input logic [1:0] rp, input logic ar);
    chk({tag, " level_o"}, int'(lv), 0);
    chk({tag, " rise_o"}, int'(rs), 0);
    chk({tag, " fall_o"}, int'(fl), 0);
    chk({tag, " repeat_o"}, int'(rp), 0);
    chk({tag, " any_rise_o"}, int'(ar), 0);
  endtask

  // Monitors: any pulse on an output is a DUT transaction matched against the queue.
  always @(negedge clk) begin
    while (q0.size() > 0 && q0[0].cyc < cyc) begin
      chk("dut missing event", cyc, q0[0].cyc);
      void'(q0.pop_front());
    end
    if (rs0 != 2'b00 || fl0 != 2'b00 || rp0 != 2'b00) begin
      if (q0.size() == 0) chk("dut unexpected event", int'({rs0, fl0, rp0}), 0);
      else cmp("dut", q0.pop_front(), lv0, rs0, fl0, rp0, ar0);
    end
  end

  always @(negedge clk) begin
    while (q1.size() > 0 && q1[0].cyc < cyc) begin
      chk("dut_inv missing event", cyc, q1[0].cyc);
      void'(q1.pop_front());
    end
    if (rs1 != 2'b00 || fl1 != 2'b00 || rp1 != 2'b00) begin
      if (q1.size() == 0) chk("dut_inv unexpected event", int'({rs1, fl1, rp1}), 0);
      else cmp("dut_inv", q1.pop_front(), lv1, rs1, fl1, rp1, ar1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int t;
    bit [0:4] bnc;
    bnc = 5'b10110;

    repeat (3) @(negedge clk);
    chk_zero("reset dut", lv0, rs0, fl0, rp0, ar0);
    chk_zero("reset dut_inv", lv1, rs1, fl1, rp1, ar1);
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    // Single rise and fall on channel 0
    t = cyc; din = 2'b01;
    push(0, t + 6, 2'b01, 2'b01, 2'b00, 2'b00);
    wait_until(t + 6); din = 2'b00;
    push(0, t + 12, 2'b00, 2'b00, 2'b01, 2'b00);
    wait_until(t + 16);

    // Three-cycle pulse is one short of the threshold: no activity
    t = cyc; din = 2'b01;
    wait_until(t + 3); din = 2'b00;
    wait_until(t + 14);

    // Bouncing channel 1 settles high after the last bounce
    t = cyc;
    for (int i = 0; i < 5; i++) begin
      din[1] = bnc[i];
      @(negedge clk);
    end
    din[1] = 1'b1;
    push(0, t + 11, 2'b10, 2'b10, 2'b00, 2'b00);
    wait_until(t + 11); din[1] = 1'b0;
    push(0, t + 17, 2'b00, 2'b00, 2'b10, 2'b00);
    wait_until(t + 21);

    // Simultaneous rises; inverted channel driven low
    t = cyc; din = 2'b11; din_inv = 2'b01;
    push(0, t + 6, 2'b11, 2'b11, 2'b00, 2'b00);
    push(1, t + 6, 2'b11, 2'b11, 2'b00, 2'b00);
    wait_until(t + 6); din = 2'b00; din_inv = 2'b10;
    push(0, t + 12, 2'b00, 2'b00, 2'b11, 2'b00);
    push(1, t + 12, 2'b00, 2'b00, 2'b11, 2'b00);
    wait_until(t + 16);

    // Reset mid-count discards it; held input rises 6 edges after release
    t = cyc; din = 2'b01;
    wait_until(t + 4); rstn = 1'b0;
    wait_until(t + 5);
    chk_zero("midreset dut", lv0, rs0, fl0, rp0, ar0);
    chk_zero("midreset dut_inv", lv1, rs1, fl1, rp1, ar1);
    wait_until(t + 6); rstn = 1'b1;
    push(0, t + 12, 2'b01, 2'b01, 2'b00, 2'b00);
    wait_until(t + 12); din = 2'b00;
    push(0, t + 18, 2'b00, 2'b00, 2'b01, 2'b00);
    wait_until(t + 22);

    // Long hold: repeat pulses only when the feature is built in
    t = cyc; din = 2'b01;
    push(0, t + 6, 2'b01, 2'b01, 2'b00, 2'b00);
`ifdef DEBOUNCE_BANK_REPEAT_EN
    push(0, t + 14, 2'b01, 2'b00, 2'b00, 2'b01);
    push(0, t + 17, 2'b01, 2'b00, 2'b00, 2'b01);
    push(0, t + 20, 2'b01, 2'b00, 2'b00, 2'b01);
    push(0, t + 23, 2'b01, 2'b00, 2'b00, 2'b01);
`endif
    wait_until(t + 20); din = 2'b00;
    push(0, t + 26, 2'b00, 2'b00, 2'b01, 2'b00);
    wait_until(t + 36);

    chk("dut pending events", q0.size(), 0);
    chk("dut_inv pending events", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
